// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the reg_pipe register pipeline.
package reg_pipe_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 3;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_if.sv
// Upstream/downstream handshake bundle for reg_pipe; slave is the pipeline view.
interface reg_pipe_if #(
  parameter int WIDTH = 8
) ();

  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport master (
    output flush,
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/reg_pipe_stage.sv
// One pipeline stage: a valid bit plus a WIDTH-bit data register.
module reg_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk1,
  input  logic             s_reset_n,
  input  logic             flush,
  input  logic             load,
  input  logic             adv,
  input  logic [WIDTH-1:0] d_in,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  // Valid bit: set on load, cleared when the word moves on or on flush.
  always_ff @(posedge clk1) begin
    if (!s_reset_n) begin
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
    end else if (adv) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Data register: only written on load, so stalled words are never overwritten.
  always_ff @(posedge clk1) begin
    if (!s_reset_n) begin
      data_r <= {WIDTH{1'b0}};
    end else if (load) begin
      data_r <= d_in;
    end else begin
      data_r <= data_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/reg_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing and flush.
// Optional occupancy counter and port enabled by REG_PIPE_OCCUPANCY_EN.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                          clk1,
  input  logic                          s_reset_n,
  reg_pipe_if.slave                     bus
`ifdef REG_PIPE_OCCUPANCY_EN
  ,
  output logic [occ_width(DEPTH)-1:0]   occupancy
`endif
);

  logic [DEPTH-1:0] valid_s;
  logic [DEPTH-1:0] adv_s;
  logic [DEPTH-1:0] load_s;
  logic [WIDTH-1:0] data_s [DEPTH];
  logic             in_ready_s;
  logic             in_xfer_s;
  logic             out_valid_s;
  logic             out_xfer_s;

  // Advance chain from the output stage back to stage 0, plus per-stage loads.
  always_comb begin
    adv_s  = {DEPTH{1'b0}};
    load_s = {DEPTH{1'b0}};
    adv_s[DEPTH-1] = valid_s[DEPTH-1] & bus.out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv_s[i] = valid_s[i] & (~valid_s[i+1] | adv_s[i+1]);
    end
    in_ready_s  = ~bus.flush & (~valid_s[0] | adv_s[0]);
    in_xfer_s   = bus.in_valid & in_ready_s;
    out_valid_s = valid_s[DEPTH-1] & ~bus.flush;
    out_xfer_s  = out_valid_s & bus.out_ready;
    load_s[0]   = in_xfer_s;
    for (int i = 1; i < DEPTH; i++) begin
      load_s[i] = adv_s[i-1] & ~bus.flush;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] d_in_s;
    if (g == 0) begin : g_first
      assign d_in_s = bus.in_data;
    end else begin : g_rest
      assign d_in_s = data_s[g-1];
    end

    reg_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk1      (clk1),
      .s_reset_n (s_reset_n),
      .flush     (bus.flush),
      .load      (load_s[g]),
      .adv       (adv_s[g]),
      .d_in      (d_in_s),
      .valid     (valid_s[g]),
      .data      (data_s[g])
    );
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = data_s[DEPTH-1];

`ifdef REG_PIPE_OCCUPANCY_EN
  localparam int OCC_W = occ_width(DEPTH);
  logic [OCC_W-1:0] occ_r;

  // Occupancy tracks transfers at both ends; simultaneous in/out leaves it unchanged.
  always_ff @(posedge clk1) begin
    if (!s_reset_n) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (bus.flush) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (in_xfer_s && !out_xfer_s) begin
      occ_r <= occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
    end else if (out_xfer_s && !in_xfer_s) begin
      occ_r <= occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
    end else begin
      occ_r <= occ_r;
    end
  end

  assign occupancy = occ_r;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Directed self-checking bench for reg_pipe with WIDTH = 8, DEPTH = 3.
module tb_reg_pipe;

  logic clk1;
  logic s_reset_n;
  int   n_chk;
  int   n_pass;

  reg_pipe_if #(.WIDTH(8)) bus ();

`ifdef REG_PIPE_OCCUPANCY_EN
  logic [1:0] occupancy;
`endif

  reg_pipe #(
    .WIDTH (8),
    .DEPTH (3)
  ) dut (
    .clk1      (clk1),
    .s_reset_n (s_reset_n),
    .bus       (bus)
`ifdef REG_PIPE_OCCUPANCY_EN
    ,
    .occupancy (occupancy)
`endif
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_occ(input string tag, input int exp);
`ifdef REG_PIPE_OCCUPANCY_EN
    chk(tag, 32'(occupancy), 32'(exp));
`endif
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk         = 0;
    n_pass        = 0;
    s_reset_n     = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    tick();
    tick();
    s_reset_n = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'h00);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk_occ("rst_occ", 0);

    // 1. Streaming
    drive(1'b1, 8'h11, 1'b1);
    chk("s1_rdy0", 32'(bus.in_ready), 32'd1);
    chk("s1_ov0", 32'(bus.out_valid), 32'd0);
    tick();
    drive(1'b1, 8'h22, 1'b1);
    chk("s1_rdy1", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b1, 8'h33, 1'b1);
    chk("s1_rdy2", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("s1_ov_a", 32'(bus.out_valid), 32'd1);
    chk("s1_d_a", 32'(bus.out_data), 32'h11);
    tick();
    chk("s1_ov_b", 32'(bus.out_valid), 32'd1);
    chk("s1_d_b", 32'(bus.out_data), 32'h22);
    tick();
    chk("s1_ov_c", 32'(bus.out_valid), 32'd1);
    chk("s1_d_c", 32'(bus.out_data), 32'h33);
    tick();
    chk("s1_empty", 32'(bus.out_valid), 32'd0);
    chk_occ("s1_occ", 0);

    // 2. Backpressure
    drive(1'b1, 8'hA1, 1'b0);
    chk("s2_rdy_a1", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b1, 8'hA2, 1'b0);
    chk("s2_rdy_a2", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b1, 8'hA3, 1'b0);
    chk("s2_rdy_a3", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b1, 8'hA4, 1'b0);
    chk("s2_rdy_a4", 32'(bus.in_ready), 32'd0);
    chk("s2_head", 32'(bus.out_data), 32'hA1);
    chk_occ("s2_occ_full", 3);
    tick();
    chk("s2_rdy_hold", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 8'hA4, 1'b1);
    chk("s2_rdy_rel", 32'(bus.in_ready), 32'd1);
    chk("s2_d_a1", 32'(bus.out_data), 32'hA1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("s2_d_a2", 32'(bus.out_data), 32'hA2);
    tick();
    chk("s2_d_a3", 32'(bus.out_data), 32'hA3);
    tick();
    chk("s2_ov_a4", 32'(bus.out_valid), 32'd1);
    chk("s2_d_a4", 32'(bus.out_data), 32'hA4);
    tick();
    chk("s2_empty", 32'(bus.out_valid), 32'd0);

    // 3. Bubble collapse under backpressure
    drive(1'b1, 8'h5C, 1'b0);
    chk("s3_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("s3_ov_1", 32'(bus.out_valid), 32'd0);
    tick();
    chk("s3_ov_2", 32'(bus.out_valid), 32'd0);
    tick();
    chk("s3_ov_3", 32'(bus.out_valid), 32'd1);
    chk("s3_d", 32'(bus.out_data), 32'h5C);
    chk("s3_rdy_after", 32'(bus.in_ready), 32'd1);
    chk_occ("s3_occ", 1);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    chk("s3_drained", 32'(bus.out_valid), 32'd0);

    // 4. Full pipeline with simultaneous in/out
    drive(1'b1, 8'h01, 1'b0);
    tick();
    drive(1'b1, 8'h02, 1'b0);
    tick();
    drive(1'b1, 8'h03, 1'b0);
    tick();
    drive(1'b1, 8'h04, 1'b1);
    chk("s4_rdy", 32'(bus.in_ready), 32'd1);
    chk("s4_d_01", 32'(bus.out_data), 32'h01);
    chk_occ("s4_occ_pre", 3);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("s4_d_02", 32'(bus.out_data), 32'h02);
    chk("s4_rdy_full", 32'(bus.in_ready), 32'd0);
    chk_occ("s4_occ_post", 3);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    tick();
    tick();
    chk("s4_drained", 32'(bus.out_valid), 32'd0);

    // 5. Flush with two words in flight
    drive(1'b1, 8'hB1, 1'b0);
    tick();
    drive(1'b1, 8'hB2, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk("s5_ov_pre", 32'(bus.out_valid), 32'd1);
    bus.flush = 1'b1;
    drive(1'b1, 8'hC0, 1'b1);
    chk("s5_rdy_fl", 32'(bus.in_ready), 32'd0);
    chk("s5_ov_fl", 32'(bus.out_valid), 32'd0);
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    chk("s5_ov_after", 32'(bus.out_valid), 32'd0);
    chk("s5_data_kept", 32'(bus.out_data), 32'hB1);
    chk_occ("s5_occ", 0);
    tick();
    chk("s5_still_empty", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 8'h77, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("s5_77_1", 32'(bus.out_valid), 32'd0);
    tick();
    chk("s5_77_2", 32'(bus.out_valid), 32'd0);
    tick();
    chk("s5_77_ov", 32'(bus.out_valid), 32'd1);
    chk("s5_77_d", 32'(bus.out_data), 32'h77);
    tick();

    // 6. Reset while full
    drive(1'b1, 8'hD1, 1'b0);
    tick();
    drive(1'b1, 8'hD2, 1'b0);
    tick();
    drive(1'b1, 8'hD3, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    chk("s6_d_pre", 32'(bus.out_data), 32'hD1);
    s_reset_n = 1'b0;
    tick();
    s_reset_n = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    chk("s6_ov", 32'(bus.out_valid), 32'd0);
    chk("s6_d", 32'(bus.out_data), 32'h00);
    chk("s6_rdy", 32'(bus.in_ready), 32'd1);
    chk_occ("s6_occ", 0);
    tick();
    chk("s6_ov_next", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
